// File: rtl/prv_trap_sequencer.sv
// prv_trap_sequencer
// Prioritises synchronous exceptions, enabled interrupts and mret requests,
// waits for the pipeline to drain, then issues a single-cycle PC redirect
// together with the trap record used to update mcause/mepc/mtval.
// Optional build macro: PRV_INT_SYNC_EN -- when defined, int_lines pass
// through a two-flop synchroniser before masking (adds two cycles of
// interrupt-to-capture latency).
module prv_trap_sequencer #(
    parameter int NUM_INT = 16,
    parameter int NUM_EXC = 16,
    parameter int XLEN    = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NUM_EXC-1:0] exc_vec,
    input  logic [XLEN-1:0]    exc_epc,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic [NUM_INT-1:0] int_lines,
    input  logic [NUM_INT-1:0] int_en,
    input  logic               glob_ie,
    input  logic [XLEN-1:0]    int_epc,
    input  logic               ret,
    input  logic [XLEN-1:0]    mepc_in,
    input  logic [XLEN-1:0]    mtvec_in,
    input  logic               pipe_clear,
    output logic               insert_pc,
    output logic [XLEN-1:0]    priv_pc,
    output logic               intr,
    output logic               trap_valid,
    output logic [XLEN-1:0]    trap_cause,
    output logic [XLEN-1:0]    trap_epc,
    output logic [XLEN-1:0]    trap_tval,
    output logic               busy
);

    // Cause codes never exceed 31, so five bits hold any index.
    localparam int CW = 5;

    // Fixed-priority orders; earlier entries win.
    localparam int EXC_PRI [0:10] = '{3, 1, 2, 0, 8, 9, 11, 6, 4, 7, 5};
    localparam int INT_PRI [0:5]  = '{11, 3, 7, 9, 1, 5};

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRAIN  = 2'b01,
        INSERT = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            intr_q, intr_d;
    logic            ret_q, ret_d;
    logic [CW-1:0]   cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;

    logic [NUM_INT-1:0] int_src_s;
    logic               exc_pend_s;
    logic               int_take_s;
    logic [XLEN-1:0]    base_s;
    logic [XLEN-1:0]    cause_ext_s;

    // Exception select: listed causes in table order, then the rest lowest index first.
    function automatic logic [CW-1:0] pick_exc(input logic [NUM_EXC-1:0] v);
        logic [31:0]   vx;
        logic [CW-1:0] sel;
        logic          listed;
        vx  = 32'(v);
        sel = {CW{1'b0}};
        for (int i = 31; i >= 0; i--) begin
            listed = 1'b0;
            for (int k = 0; k < 11; k++) begin
                listed = listed | (EXC_PRI[k] == i);
            end
            sel = (vx[i] && !listed) ? CW'(i) : sel;
        end
        for (int k = 10; k >= 0; k--) begin
            sel = vx[EXC_PRI[k]] ? CW'(EXC_PRI[k]) : sel;
        end
        return sel;
    endfunction

    // Interrupt select: listed lines in table order, then the rest highest index first.
    function automatic logic [CW-1:0] pick_int(input logic [NUM_INT-1:0] v);
        logic [31:0]   vx;
        logic [CW-1:0] sel;
        logic          listed;
        vx  = 32'(v);
        sel = {CW{1'b0}};
        for (int i = 0; i < 32; i++) begin
            listed = 1'b0;
            for (int k = 0; k < 6; k++) begin
                listed = listed | (INT_PRI[k] == i);
            end
            sel = (vx[i] && !listed) ? CW'(i) : sel;
        end
        for (int k = 5; k >= 0; k--) begin
            sel = vx[INT_PRI[k]] ? CW'(INT_PRI[k]) : sel;
        end
        return sel;
    endfunction

`ifdef PRV_INT_SYNC_EN
    logic [NUM_INT-1:0] int_sync1_q;
    logic [NUM_INT-1:0] int_sync2_q;

    // Two-flop synchroniser for the asynchronous interrupt request lines.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            int_sync1_q <= {NUM_INT{1'b0}};
            int_sync2_q <= {NUM_INT{1'b0}};
        end else begin
            int_sync1_q <= int_lines;
            int_sync2_q <= int_sync1_q;
        end
    end

    assign int_src_s = int_sync2_q;
`else
    assign int_src_s = int_lines;
`endif

    assign exc_pend_s = |exc_vec;
    assign int_take_s = glob_ie & (|(int_src_s & int_en));

    // State and captured trap record.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
            ret_q   <= 1'b0;
            cause_q <= {CW{1'b0}};
            epc_q   <= {XLEN{1'b0}};
            tval_q  <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            intr_q  <= intr_d;
            ret_q   <= ret_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

    // Next-state and capture logic; only IDLE accepts new events.
    always_comb begin
        state_d = state_q;
        intr_d  = intr_q;
        ret_d   = ret_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        case (state_q)
            IDLE: begin
                if (exc_pend_s) begin
                    state_d = DRAIN;
                    intr_d  = 1'b0;
                    ret_d   = 1'b0;
                    cause_d = pick_exc(exc_vec);
                    epc_d   = exc_epc;
                    tval_d  = exc_tval;
                end else if (int_take_s) begin
                    state_d = DRAIN;
                    intr_d  = 1'b1;
                    ret_d   = 1'b0;
                    cause_d = pick_int(int_src_s & int_en);
                    epc_d   = int_epc;
                    tval_d  = {XLEN{1'b0}};
                end else if (ret) begin
                    state_d = DRAIN;
                    intr_d  = 1'b0;
                    ret_d   = 1'b1;
                    cause_d = {CW{1'b0}};
                    epc_d   = mepc_in;
                    tval_d  = {XLEN{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (pipe_clear) begin
                    state_d = INSERT;
                end else begin
                    state_d = DRAIN;
                end
            end
            INSERT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign base_s      = {mtvec_in[XLEN-1:2], 2'b00};
    assign cause_ext_s = XLEN'(cause_q);

    // Redirect and trap record, driven only during INSERT; mtvec is read live here.
    always_comb begin
        insert_pc  = 1'b0;
        priv_pc    = {XLEN{1'b0}};
        intr       = 1'b0;
        trap_valid = 1'b0;
        trap_cause = {XLEN{1'b0}};
        trap_epc   = {XLEN{1'b0}};
        trap_tval  = {XLEN{1'b0}};
        busy       = (state_q != IDLE);
        if (state_q == INSERT) begin
            insert_pc = 1'b1;
            if (ret_q) begin
                priv_pc = epc_q;
            end else begin
                if (intr_q && (mtvec_in[1:0] == 2'b01)) begin
                    priv_pc = base_s + (cause_ext_s << 2'd2);
                end else begin
                    priv_pc = base_s;
                end
                intr                   = intr_q;
                trap_valid             = 1'b1;
                trap_cause             = cause_ext_s;
                trap_cause[XLEN-1]     = intr_q;
                trap_epc               = epc_q;
                trap_tval              = tval_q;
            end
        end else begin
            insert_pc = 1'b0;
        end
    end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Scoreboard bench for prv_trap_sequencer: stimulus pushes expected redirect
// records (including the cycle they must appear in); a negedge monitor pops
// and compares whenever insert_pc is seen.
module tb_prv_trap_sequencer;

    localparam int XLEN    = 32;
    localparam int NUM_INT = 16;
    localparam int NUM_EXC = 16;
`ifdef PRV_INT_SYNC_EN
    localparam int INT_LAT = 4;
`else
    localparam int INT_LAT = 2;
`endif

    logic               CLK;
    logic               nRST;
    logic [NUM_EXC-1:0] exc_vec;
    logic [XLEN-1:0]    exc_epc;
    logic [XLEN-1:0]    exc_tval;
    logic [NUM_INT-1:0] int_lines;
    logic [NUM_INT-1:0] int_en;
    logic               glob_ie;
    logic [XLEN-1:0]    int_epc;
    logic               ret;
    logic [XLEN-1:0]    mepc_in;
    logic [XLEN-1:0]    mtvec_in;
    logic               pipe_clear;
    logic               insert_pc;
    logic [XLEN-1:0]    priv_pc;
    logic               intr;
    logic               trap_valid;
    logic [XLEN-1:0]    trap_cause;
    logic [XLEN-1:0]    trap_epc;
    logic [XLEN-1:0]    trap_tval;
    logic               busy;

    prv_trap_sequencer #(.NUM_INT(NUM_INT), .NUM_EXC(NUM_EXC), .XLEN(XLEN)) dut (
        .CLK(CLK), .nRST(nRST), .exc_vec(exc_vec), .exc_epc(exc_epc),
        .exc_tval(exc_tval), .int_lines(int_lines), .int_en(int_en),
        .glob_ie(glob_ie), .int_epc(int_epc), .ret(ret), .mepc_in(mepc_in),
        .mtvec_in(mtvec_in), .pipe_clear(pipe_clear), .insert_pc(insert_pc),
        .priv_pc(priv_pc), .intr(intr), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] pc;
        logic        in;
        logic        tv;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_ins = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic in_, input logic tv,
                        input logic [31:0] cause, input logic [31:0] epc,
                        input logic [31:0] tval, input int lat);
        exp_t e;
        e.pc = pc; e.in = in_; e.tv = tv; e.cause = cause;
        e.epc = epc; e.tval = tval; e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 40) begin
            step(1);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d records still pending, busy=%0b", sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_insert_pc"}, 32'(insert_pc), 32'd0);
        chk({tag, "_priv_pc"}, priv_pc, 32'd0);
        chk({tag, "_intr"}, 32'(intr), 32'd0);
        chk({tag, "_trap_valid"}, 32'(trap_valid), 32'd0);
        chk({tag, "_trap_cause"}, trap_cause, 32'd0);
        chk({tag, "_trap_epc"}, trap_epc, 32'd0);
        chk({tag, "_trap_tval"}, trap_tval, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: compare every redirect against the oldest expected record.
    always @(negedge CLK) begin
        if (insert_pc === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_insert: insert_pc=1 with nothing expected at cycle %0d", cyc);
            end else begin
                cur = sb.pop_front();
                chk("priv_pc", priv_pc, cur.pc);
                chk("intr", 32'(intr), 32'(cur.in));
                chk("trap_valid", 32'(trap_valid), 32'(cur.tv));
                chk("trap_cause", trap_cause, cur.cause);
                chk("trap_epc", trap_epc, cur.epc);
                chk("trap_tval", trap_tval, cur.tval);
                chk("latency", 32'(cyc), 32'(cur.cyc));
            end
            chk("one_shot", 32'(prev_ins), 32'd0);
        end
        prev_ins = insert_pc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0; exc_vec = '0; exc_epc = '0; exc_tval = '0;
        int_lines = '0; int_en = 16'hFFFF; glob_ie = 1'b0; int_epc = 32'h300;
        ret = 1'b0; mepc_in = '0; mtvec_in = 32'h8000_0001; pipe_clear = 1'b1;
        #3;
        check_zero("reset");
        step(2);
        nRST = 1'b1;
        step(1);

        // Exception cause 2, vectored mtvec ignored for exceptions.
        exc_vec = 16'h0004; exc_epc = 32'h100; exc_tval = 32'hDEAD;
        push(32'h8000_0000, 1'b0, 1'b1, 32'd2, 32'h100, 32'hDEAD, 2);
        step(1); exc_vec = '0;
        wait_done();

        // Interrupts 7 and 11: 11 wins, vectored to base + 44.
        glob_ie = 1'b1; int_lines = 16'h0880;
        push(32'h8000_002C, 1'b1, 1'b1, 32'h8000_000B, 32'h300, 32'h0, INT_LAT);
        step(INT_LAT - 1); int_lines = '0;
        wait_done();

        // Exception 3 + interrupt 3 + ret together: exception first, then interrupt.
        exc_vec = 16'h0008; exc_epc = 32'h400; exc_tval = 32'h44;
        int_lines = 16'h0008; ret = 1'b1; mepc_in = 32'h2000;
        push(32'h8000_0000, 1'b0, 1'b1, 32'd3, 32'h400, 32'h44, 2);
        push(32'h8000_000C, 1'b1, 1'b1, 32'h8000_0003, 32'h300, 32'h0, 5);
        step(1); exc_vec = '0; ret = 1'b0;
        step(3); int_lines = '0;
        wait_done();

        // mret with pipe_clear low for three DRAIN cycles.
        pipe_clear = 1'b0; ret = 1'b1; mepc_in = 32'h2000;
        push(32'h2000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5);
        step(1); ret = 1'b0;
        chk("busy_drain", 32'(busy), 32'd1);
        step(3); pipe_clear = 1'b1;
        wait_done();

        // mtvec read at INSERT: change it while draining; bits 4..11 -> cause 8.
        pipe_clear = 1'b0; exc_vec = 16'h0FF0; exc_epc = 32'h500; exc_tval = 32'h55;
        push(32'h9000_0000, 1'b0, 1'b1, 32'd8, 32'h500, 32'h55, 3);
        step(1); exc_vec = '0; mtvec_in = 32'h9000_0000;
        step(1); pipe_clear = 1'b1;
        wait_done();

        // Unlisted exceptions 12 and 15: lowest index wins.
        mtvec_in = 32'h0000_1000; exc_vec = 16'h9000;
        push(32'h1000, 1'b0, 1'b1, 32'd12, 32'h500, 32'h55, 2);
        step(1); exc_vec = '0;
        wait_done();

        // Exceptions 0,1,2: cause 1 wins.
        exc_vec = 16'h0007;
        push(32'h1000, 1'b0, 1'b1, 32'd1, 32'h500, 32'h55, 2);
        step(1); exc_vec = '0;
        wait_done();

        // Unlisted interrupts 2 and 12: highest index wins, vectored.
        mtvec_in = 32'h4000_0001; int_lines = 16'h1004;
        push(32'h4000_0030, 1'b1, 1'b1, 32'h8000_000C, 32'h300, 32'h0, INT_LAT);
        step(INT_LAT - 1); int_lines = '0;
        wait_done();

        // Direct-mode mtvec, interrupts 1 and 5: cause 1 at base.
        mtvec_in = 32'h0000_1000; int_lines = 16'h0022;
        push(32'h1000, 1'b1, 1'b1, 32'h8000_0001, 32'h300, 32'h0, INT_LAT);
        step(INT_LAT - 1); int_lines = '0;
        wait_done();

        // int_en masks line 11, leaving line 1.
        mtvec_in = 32'h0000_1001; int_en = 16'h0002; int_lines = 16'h0802;
        push(32'h1004, 1'b1, 1'b1, 32'h8000_0001, 32'h300, 32'h0, INT_LAT);
        step(INT_LAT - 1); int_lines = '0; int_en = 16'hFFFF;
        wait_done();

        // Vectored target wraps modulo 2^32 (line 15).
        mtvec_in = 32'hFFFF_FFE1; int_lines = 16'h8000;
        push(32'h0000_001C, 1'b1, 1'b1, 32'h8000_000F, 32'h300, 32'h0, INT_LAT);
        step(INT_LAT - 1); int_lines = '0;
        wait_done();

        // Global interrupt disable: no trap, stays idle.
        glob_ie = 1'b0; int_lines = 16'h0800;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("gie_off_busy", 32'(busy), 32'd0);
        end
        int_lines = '0;
        step(3);

        // Reset during DRAIN aborts; nothing issued afterwards.
        pipe_clear = 1'b0; exc_vec = 16'h0001;
        step(1);
        chk("busy_before_abort", 32'(busy), 32'd1);
        nRST = 1'b0; exc_vec = '0;
        #1;
        check_zero("abort");
        step(2);
        nRST = 1'b1; pipe_clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("post_abort_busy", 32'(busy), 32'd0);
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
